uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBIT data bits LSB first, configurable stop length.
// The line is synchronized, the start bit is qualified at its midpoint, and every
// later bit is sampled 16 ticks after the previous sample point.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            rx_i,
    input  logic            s_tick_i,
    output logic [DBIT-1:0] dout_o,
    output logic            rx_done_tick_o,
    output logic            frame_err_o
);

    // Tick counter widens only when the stop length needs more than 16 ticks.
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] SHalf = SW'(7);
    localparam logic [SW-1:0] SFull = SW'(15);
    localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          r_state;
    logic [1:0]      r_sync;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_done;
    logic            r_ferr;
    logic            w_rx_s;

    assign w_rx_s         = r_sync[1];
    assign dout_o         = r_b;
    assign rx_done_tick_o = r_done;
    assign frame_err_o    = r_ferr;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    // Receive FSM with counters, shift register and registered status outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    // A line already low here starts a frame at once (back-to-back).
                    if (!w_rx_s) begin
                        r_state <= StStart;
                        r_s     <= '0;
                    end
                end
                StStart: begin
                    if (s_tick_i) begin
                        if (r_s == SHalf) begin
                            // Midpoint of start bit: high means it was a glitch.
                            if (!w_rx_s) begin
                                r_state <= StData;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= StIdle;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                StData: begin
                    if (s_tick_i) begin
                        if (r_s == SFull) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n == NLast) begin
                                r_state <= StStop;
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                StStop: begin
                    if (s_tick_i) begin
                        if (r_s == SStop) begin
                            // Bad stop still completes the frame, flagged via frame_err_o.
                            r_state <= StIdle;
                            r_s     <= '0;
                            r_done  <= 1'b1;
                            r_ferr  <= ~w_rx_s;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven tick-by-tick, expected words are
// queued at send time and a monitor compares them on every done pulse.
module tb_uart_rx;

    logic       clk_i;
    logic       reset_i;
    logic       rx_i;
    logic       s_tick_i;
    logic [7:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_err;
    logic tick_en;
    int   tcnt;

    uart_rx #(
        .DBIT   (8),
        .SB_TICK(16)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .rx_i          (rx_i),
        .s_tick_i      (s_tick_i),
        .dout_o        (dout_o),
        .rx_done_tick_o(rx_done_tick_o),
        .frame_err_o   (frame_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One tick every 4 clocks, gated by tick_en for the freeze test.
    initial begin
        s_tick_i = 1'b0;
        tcnt     = 0;
        forever begin
            @(posedge clk_i);
            #1;
            s_tick_i = tick_en && (tcnt == 3);
            tcnt     = (tcnt + 1) % 4;
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest queued frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rx_done_tick_o) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: dout=%h ferr=%b, expected no done pulse",
                             dout_o, frame_err_o);
                end else begin
                    e = q.pop_front();
                    if (dout_o !== e.data || frame_err_o !== e.ferr) begin
                        n_err++;
                        $display("FAIL frame: dout=%h ferr=%b, expected dout=%h ferr=%b",
                                 dout_o, frame_err_o, e.data, e.ferr);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk_i);
            while (!s_tick_i) @(negedge clk_i);
        end
    endtask

    // Bad stop is held low only past the stop sample point, then released so the
    // immediate restart in idle sees a high line at the start-bit midpoint.
    task automatic send_frame(input logic [7:0] data, input logic bad_stop);
        q.push_back('{data: data, ferr: bad_stop});
        rx_i = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            wait_ticks(16);
        end
        if (bad_stop) begin
            rx_i = 1'b0;
            wait_ticks(10);
            rx_i = 1'b1;
            wait_ticks(6);
        end else begin
            rx_i = 1'b1;
            wait_ticks(16);
        end
    endtask

    initial begin
        logic [7:0] pre;
        n_vec   = 0;
        n_err   = 0;
        tick_en = 1'b1;
        rx_i    = 1'b1;
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_dout", dout_o, 8'h00);
        check("reset_done", {7'd0, rx_done_tick_o}, 8'h00);
        check("reset_ferr", {7'd0, frame_err_o}, 8'h00);
        reset_i = 1'b0;
        wait_ticks(20);

        send_frame(8'h55, 1'b0);
        wait_ticks(20);

        // Low glitch shorter than half a bit.
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        wait_ticks(30);
        check("glitch_dout", dout_o, 8'h55);

        send_frame(8'hA5, 1'b1);
        wait_ticks(20);
        send_frame(8'h3C, 1'b0);
        wait_ticks(20);

        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h81, 1'b0);
        wait_ticks(20);

        // Reset during data bit 4 of 0xC3.
        pre  = 8'hC3;
        rx_i = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_i = pre[i];
            wait_ticks(16);
        end
        rx_i = pre[4];
        wait_ticks(8);
        reset_i = 1'b1;
        #2;
        check("midreset_dout", dout_o, 8'h00);
        check("midreset_done", {7'd0, rx_done_tick_o}, 8'h00);
        check("midreset_ferr", {7'd0, frame_err_o}, 8'h00);
        rx_i = 1'b1;
        repeat (5) @(negedge clk_i);
        reset_i = 1'b0;
        wait_ticks(40);
        send_frame(8'h96, 1'b0);
        wait_ticks(20);

        // Freeze ticks after three data bits of 0x5A: b = {3'b010, 0x96[7:3]} = 0x52.
        fork
            send_frame(8'h5A, 1'b0);
            begin
                wait_ticks(64);
                tick_en = 1'b0;
                repeat (1000) @(negedge clk_i);
                check("freeze_dout", dout_o, 8'h52);
                tick_en = 1'b1;
            end
        join
        wait_ticks(40);

        check("pending_frames", 8'(q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
